logs_wmixer: RTL and testbench

- Parametrised successor to the popcount PWM mixer.
- Mixes N one-bit audio lines using a per-channel gain in place of a plain popcount.
- Saturates the weighted sum and drives one 1-bit output in one of two run-time modes: glitch-free PWM (duty latched once per period) or first-order sigma-delta.
- Sits between the tone/noise generators and the audio pad; also reports a sticky clip condition.

---
 rtl/logs_audio_pkg.sv | 15 +
 rtl/logs_wmixer_if.sv | 25 ++
 rtl/logs_weighted_sum.sv | 31 +++
 rtl/logs_wmixer.sv | 123 ++++++++++++
 tb/tb_logs_wmixer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/logs_audio_pkg.sv
// Shared audio-mixer package: output mode encodings and the sum-width helper
// used to size the weighted channel sum.
package logs_audio_pkg;

    typedef enum logic {
        MODE_PWM = 1'b0,
        MODE_SDM = 1'b1
    } mode_e;

    // Width needed to hold the sum of n channels of gw-bit gains without overflow.
    function automatic int calc_sw(input int n, input int gw);
        return gw + $clog2(n + 1);
    endfunction

endpackage

// File: rtl/logs_wmixer_if.sv
// Bus bundle for the weighted mixer: audio lines, channel controls and the
// mixed 1-bit output with its status strobes.
interface logs_wmixer_if #(
    parameter int N  = 4,
    parameter int GW = 3
);
    logic [N-1:0]    audio_in;
    logic [N-1:0]    audio_mask;
    logic [N*GW-1:0] gain;
    logic            mode;
    logic            clip_clr;
    logic            audio_out;
    logic            period_start;
    logic            clip;

    modport master (
        output audio_in, audio_mask, gain, mode, clip_clr,
        input  audio_out, period_start, clip
    );

    modport slave (
        input  audio_in, audio_mask, gain, mode, clip_clr,
        output audio_out, period_start, clip
    );
endinterface

// File: rtl/logs_weighted_sum.sv
// Combinational masked gain sum: each enabled, active channel contributes its
// gain; the result is wide enough that it never overflows.
module logs_weighted_sum
    import logs_audio_pkg::*;
#(
    parameter int N  = 4,
    parameter int GW = 3,
    parameter int SW = calc_sw(N, GW)
) (
    input  logic [N-1:0]    i_audio_in,
    input  logic [N-1:0]    i_audio_mask,
    input  logic [N*GW-1:0] i_gain,
    output logic [SW-1:0]   o_sum
);

    logic [SW-1:0] w_term [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_term
        assign w_term[gi] = (i_audio_in[gi] & i_audio_mask[gi])
                          ? SW'(i_gain[gi*GW +: GW]) : '0;
    end

    // Adder chain over all channel terms.
    always_comb begin
        o_sum = '0;
        for (int i = 0; i < N; i++) begin
            o_sum = o_sum + w_term[i];
        end
    end

endmodule

// File: rtl/logs_wmixer.sv
// Weighted N-channel 1-bit audio mixer with saturating sum and PWM or
// first-order sigma-delta output. The sticky clip flag is only built when
// LOGS_WMIXER_CLIP_EN is defined; otherwise clip is tied low.
module logs_wmixer
    import logs_audio_pkg::*;
#(
    parameter int N  = 4,
    parameter int GW = 3,
    parameter int K  = 4
) (
    input logic         clk,
    input logic         rst,
    logs_wmixer_if.slave bus
);

    localparam int SW = calc_sw(N, GW);
    // Compare width large enough for both the raw sum and the 2^K full scale.
    localparam int CW = (SW > K + 1) ? SW : K + 1;
    localparam logic [CW-1:0] FULL_EXT = CW'(1) << K;
    localparam logic [K:0]    FULL     = {1'b1, {K{1'b0}}};
    localparam logic [K-1:0]  CNT_MAX  = '1;

    logic [SW-1:0] w_raw;
    logic [CW-1:0] w_raw_ext;
    logic          w_sat;
    logic [K:0]    w_sum_next;
    logic [K:0]    w_t;
    logic          w_mode_chg;

    logic [K:0]    r_sum_q;
    logic [K:0]    r_duty_q;
    logic [K-1:0]  r_counter;
    logic [K-1:0]  r_acc;
    mode_e         r_mode_q;
    logic          r_audio_out;
    logic          r_period_start;

    logs_weighted_sum #(
        .N  (N),
        .GW (GW),
        .SW (SW)
    ) u_sum (
        .i_audio_in   (bus.audio_in),
        .i_audio_mask (bus.audio_mask),
        .i_gain       (bus.gain),
        .o_sum        (w_raw)
    );

    assign w_raw_ext  = CW'(w_raw);
    assign w_sat      = (w_raw_ext > FULL_EXT);
    assign w_sum_next = w_sat ? FULL : w_raw_ext[K:0];
    assign w_t        = {1'b0, r_acc} + r_sum_q;
    assign w_mode_chg = (mode_e'(bus.mode) != r_mode_q);

    // Stage 1: register the saturated weighted sum and the requested mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum_q  <= '0;
            r_mode_q <= MODE_PWM;
        end else begin
            r_sum_q  <= w_sum_next;
            r_mode_q <= mode_e'(bus.mode);
        end
    end

    // Stage 2: period counter, duty latch and the selected modulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_counter      <= '0;
            r_duty_q       <= '0;
            r_acc          <= '0;
            r_audio_out    <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            // Strobe tracks the counter wrap in both modes so software timing holds.
            r_period_start <= (r_counter == CNT_MAX);
            if (w_mode_chg) begin
                // One quiet cycle with both modulators restarted from a known state.
                r_counter   <= '0;
                r_acc       <= '0;
                r_duty_q    <= r_sum_q;
                r_audio_out <= 1'b0;
            end else begin
                r_counter <= r_counter + 1'b1;
                // Duty only moves on the wrap, so a PWM period never gets a runt pulse.
                if (r_counter == CNT_MAX) begin
                    r_duty_q <= r_sum_q;
                end
                if (r_mode_q == MODE_PWM) begin
                    r_audio_out <= ({1'b0, r_counter} < r_duty_q);
                end else begin
                    r_audio_out <= w_t[K];
                    r_acc       <= w_t[K-1:0];
                end
            end
        end
    end

    assign bus.audio_out    = r_audio_out;
    assign bus.period_start = r_period_start;

`ifdef LOGS_WMIXER_CLIP_EN
    logic r_clip;

    // Sticky clip flag; a saturating update in the same cycle beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clip <= 1'b0;
        end else if (w_sat) begin
            r_clip <= 1'b1;
        end else if (bus.clip_clr) begin
            r_clip <= 1'b0;
        end
    end

    assign bus.clip = r_clip;
`else
    logic w_unused_clip_clr;
    assign w_unused_clip_clr = bus.clip_clr;
    assign bus.clip          = 1'b0;
`endif

endmodule

// File: tb/tb_logs_wmixer.sv
// Directed testbench for logs_wmixer (N=4, GW=3, K=4). Inputs change 1 ns
// after a rising edge and outputs are sampled at that same point.
module tb_logs_wmixer;

`ifdef LOGS_WMIXER_CLIP_EN
    localparam logic CLIP_SAT = 1'b1;
`else
    localparam logic CLIP_SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    logs_wmixer_if #(.N(4), .GW(3)) bus ();

    logs_wmixer #(.N(4), .GW(3), .K(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until period_start is seen, at most 40 clocks.
    task automatic wait_ps(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.period_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Record audio_out / period_start after each of n clocks, bit i = clock i.
    task automatic capture(input int n, output logic [15:0] o_pat, output logic [15:0] p_pat);
        o_pat = '0;
        p_pat = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            o_pat[i] = bus.audio_out;
            p_pat[i] = bus.period_start;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.audio_in = '0; bus.audio_mask = '0; bus.gain = '0;
        bus.mode = 1'b0; bus.clip_clr = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({bus.audio_out, bus.period_start, bus.clip} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 000", {bus.audio_out, bus.period_start, bus.clip});
        end else $display("reset_outputs ok");
    endtask

    task automatic test_pwm_basic();
        bit ok;
        logic [15:0] o, p;
        bus.gain = {3'd4, 3'd3, 3'd2, 3'd1};
        bus.audio_mask = 4'b1111;
        bus.audio_in = 4'b0101;
        rst = 1'b0;
        tick();
        wait_ps(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL pwm_basic_wait: got no period_start expected one"); end
        for (int k = 0; k < 2; k++) begin
            capture(16, o, p);
            n_cmp++;
            if (o !== 16'h000F) begin n_err++; $display("FAIL pwm_basic_out%0d: got %h expected 000f", k, o); end
            else $display("pwm_basic_out%0d %h ok", k, o);
            n_cmp++;
            if (p !== 16'h8000) begin n_err++; $display("FAIL pwm_basic_ps%0d: got %h expected 8000", k, p); end
            else $display("pwm_basic_ps%0d %h ok", k, p);
        end
    endtask

    task automatic test_saturation();
        bit ok;
        logic [15:0] o, p;
        bus.gain = {4{3'd7}};
        bus.audio_in = 4'b1111;
        tick();
        n_cmp++;
        if (bus.clip !== CLIP_SAT) begin n_err++; $display("FAIL clip_set: got %b expected %b", bus.clip, CLIP_SAT); end
        else $display("clip_set %b ok", bus.clip);
        wait_ps(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL sat_wait: got no period_start expected one"); end
        capture(16, o, p);
        n_cmp++;
        if (o !== 16'hFFFF) begin n_err++; $display("FAIL sat_out: got %h expected ffff", o); end
        else $display("sat_out %h ok", o);
        bus.clip_clr = 1'b1;
        tick();
        n_cmp++;
        if (bus.clip !== CLIP_SAT) begin n_err++; $display("FAIL clip_set_wins: got %b expected %b", bus.clip, CLIP_SAT); end
        else $display("clip_set_wins %b ok", bus.clip);
        bus.clip_clr = 1'b0;
        bus.audio_in = 4'b0000;
        tick();
        n_cmp++;
        if (bus.clip !== CLIP_SAT) begin n_err++; $display("FAIL clip_sticky: got %b expected %b", bus.clip, CLIP_SAT); end
        else $display("clip_sticky %b ok", bus.clip);
        bus.clip_clr = 1'b1;
        tick();
        bus.clip_clr = 1'b0;
        n_cmp++;
        if (bus.clip !== 1'b0) begin n_err++; $display("FAIL clip_clear: got %b expected 0", bus.clip); end
        else $display("clip_clear %b ok", bus.clip);
    endtask

    task automatic test_sigma_delta();
        logic [15:0] o, p;
        bus.gain = {3'd4, 3'd3, 3'd2, 3'd1};
        bus.audio_in = 4'b0101;
        bus.mode = 1'b1;
        tick();
        n_cmp++;
        if (bus.audio_out !== 1'b0) begin n_err++; $display("FAIL sdm_switch_quiet: got %b expected 0", bus.audio_out); end
        else $display("sdm_switch_quiet ok");
        capture(16, o, p);
        n_cmp++;
        if (o !== 16'h8888) begin n_err++; $display("FAIL sdm_quarter_out: got %h expected 8888", o); end
        else $display("sdm_quarter_out %h ok", o);
        n_cmp++;
        if (p !== 16'h8000) begin n_err++; $display("FAIL sdm_ps: got %h expected 8000", p); end
        else $display("sdm_ps %h ok", p);
        bus.audio_in = 4'b0000;
        capture(16, o, p);
        n_cmp++;
        if (o !== 16'h0000) begin n_err++; $display("FAIL sdm_zero_out: got %h expected 0000", o); end
        else $display("sdm_zero_out %h ok", o);
    endtask

    task automatic test_glitch_free();
        bit ok;
        logic [15:0] o1, p1, o2, p2, full_o, full_p;
        bus.mode = 1'b0;
        bus.audio_in = 4'b1111;
        bus.audio_mask = 4'b1111;
        tick();
        wait_ps(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL glitch_wait: got no period_start expected one"); end
        capture(5, o1, p1);
        bus.audio_mask = 4'b0000;
        capture(11, o2, p2);
        full_o = {o2[10:0], o1[4:0]};
        full_p = {p2[10:0], p1[4:0]};
        n_cmp++;
        if (full_o !== 16'h03FF) begin n_err++; $display("FAIL glitch_old_period: got %h expected 03ff", full_o); end
        else $display("glitch_old_period %h ok", full_o);
        n_cmp++;
        if (full_p !== 16'h8000) begin n_err++; $display("FAIL glitch_ps: got %h expected 8000", full_p); end
        else $display("glitch_ps %h ok", full_p);
        capture(16, o1, p1);
        n_cmp++;
        if (o1 !== 16'h0000 || p1 !== 16'h8000) begin
            n_err++; $display("FAIL glitch_new_period: got out=%h ps=%h expected out=0000 ps=8000", o1, p1);
        end else $display("glitch_new_period out=%h ps=%h ok", o1, p1);
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [15:0] o, p;
        bus.audio_mask = 4'b1111;
        bus.audio_in = 4'b1101;
        tick();
        wait_ps(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rstmid_wait: got no period_start expected one"); end
        capture(16, o, p);
        n_cmp++;
        if (o !== 16'h00FF) begin n_err++; $display("FAIL rstmid_duty8: got %h expected 00ff", o); end
        else $display("rstmid_duty8 %h ok", o);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({bus.audio_out, bus.period_start, bus.clip} !== 3'b000) begin
            n_err++; $display("FAIL rstmid_outputs: got %b expected 000", {bus.audio_out, bus.period_start, bus.clip});
        end else $display("rstmid_outputs ok");
        capture(16, o, p);
        n_cmp++;
        if (o !== 16'h0000 || p !== 16'h8000) begin
            n_err++; $display("FAIL rstmid_first_period: got out=%h ps=%h expected out=0000 ps=8000", o, p);
        end else $display("rstmid_first_period out=%h ps=%h ok", o, p);
        capture(16, o, p);
        n_cmp++;
        if (o !== 16'h00FF || p !== 16'h8000) begin
            n_err++; $display("FAIL rstmid_resume: got out=%h ps=%h expected out=00ff ps=8000", o, p);
        end else $display("rstmid_resume out=%h ps=%h ok", o, p);
    endtask

    task automatic test_mode_switch();
        bit ok;
        logic [15:0] o, p;
        bus.gain = {3'd7, 3'd5, 3'd0, 3'd0};
        bus.audio_in = 4'b1100;
        tick();
        wait_ps(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL mswitch_wait: got no period_start expected one"); end
        capture(16, o, p);
        n_cmp++;
        if (o !== 16'h0FFF) begin n_err++; $display("FAIL mswitch_duty12: got %h expected 0fff", o); end
        else $display("mswitch_duty12 %h ok", o);
        capture(9, o, p);
        n_cmp++;
        if (o[8:0] !== 9'h1FF) begin n_err++; $display("FAIL mswitch_pre: got %h expected 1ff", o[8:0]); end
        else $display("mswitch_pre %h ok", o[8:0]);
        bus.mode = 1'b1;
        tick();
        n_cmp++;
        if (bus.audio_out !== 1'b0) begin n_err++; $display("FAIL mswitch_quiet: got %b expected 0", bus.audio_out); end
        else $display("mswitch_quiet ok");
        capture(16, o, p);
        n_cmp++;
        if (o !== 16'hEEEE || p !== 16'h8000) begin
            n_err++; $display("FAIL mswitch_sdm: got out=%h ps=%h expected out=eeee ps=8000", o, p);
        end else $display("mswitch_sdm out=%h ps=%h ok", o, p);
    endtask

    initial begin
        test_reset();
        test_pwm_basic();
        test_saturation();
        test_sigma_delta();
        test_glitch_free();
        test_reset_mid();
        test_mode_switch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
